fifo_ctrl: RTL
==============

// Module: fifo_ctrl
// PURPOSE
//  Upstream control/storage stage of the synchronous FIFO. Arbitrates wr_en/rd_en, owns the
//  register-file memory, the head/tail pointers and the occupancy count. Publishes registered
//  state[2:0] and data_count[3:0], which the flag/ack decoder stage turns into
//  wr_ack/rd_ack/wr_err/rd_err/empty/full.
// PARAMETERS
//  DATA_W  32  data word width
//  DEPTH   8   number of entries; must be a power of two
//  ADDR_W  3   pointer width, equal to log2(DEPTH)
//  CNT_W   4   count width, equal to ADDR_W+1; holds values 0..DEPTH
// PORTS
//  clk         in   1       single clock; all state changes on its rising edge
//  rst         in   1       synchronous, active-high reset
//  wr_en       in   1       write request, sampled each cycle
//  rd_en       in   1       read request, sampled each cycle
//  din         in   DATA_W  write data, sampled with wr_en
//  dout        out  DATA_W  registered read data
//  state       out  3       registered op state: INIT=000 NO_OP=001 WRITE=010 WR_ERROR=011 READ=100 RD_ERROR=101
//  data_count  out  CNT_W   registered occupancy after this cycle's operation
// BEHAVIOUR
//  - Reset values: state=INIT, data_count=0, head=0, tail=0, dout=0. rst has priority over every
//    other input, including a request in the same cycle and a reset in the middle of a transfer.
//    Memory is not cleared; see CONFIGURATION.
//  - Each cycle with rst=0, state_next is chosen by priority from (wr_en, rd_en, data_count):
//      wr_en=1, rd_en=1   -> NO_OP. No transfer; pointers, count and dout unchanged.
//      wr_en=0, rd_en=0   -> NO_OP. Nothing changes.
//      wr_en only, count<DEPTH  -> WRITE. mem[tail]<=din; tail<=tail+1; count<=count+1.
//      wr_en only, count==DEPTH -> WR_ERROR. Memory, tail and count unchanged; din is dropped.
//      rd_en only, count>0      -> READ. dout<=mem[head]; head<=head+1; count<=count-1.
//      rd_en only, count==0     -> RD_ERROR. head, count and dout unchanged.
//  - The state register is updated on every edge, so each state lasts exactly one cycle and
//    reflects the request sampled on the previous edge.
//  - INIT occurs only for the first cycle after reset. From INIT, the transition rules above
//    apply unchanged.
//  - Latency: dout is valid in the same cycle that state==READ, one clock after rd_en is
//    sampled. dout holds its last read value in all other states.
//  - Pointers wrap naturally modulo DEPTH (ADDR_W bits, so 7+1 -> 0). data_count never exceeds
//    DEPTH and never underflows.
//  - data_count is the post-operation value. Example: with 7 entries, a WRITE cycle shows
//    state=WRITE and data_count=8, so the downstream stage asserts full in that same cycle.
//  - No combinational path from any input to any output.
// CONFIGURATION
//  - FIFO_MEM_CLR_EN defined: rst also clears every memory entry to 0. This creates a reset
//    fan-out to DEPTH*DATA_W flops.
//  - FIFO_MEM_CLR_EN undefined: memory has no reset and holds its contents across rst. Only the
//    pointers, count, state and dout reset.
//  - Either way, data in memory that is not between head and tail is never observable on dout.
// STRUCTURE
//  - fifo_pkg holds the shared state encodings (ST_INIT, ST_NO_OP, ST_WRITE, ST_WR_ERROR,
//    ST_READ, ST_RD_ERROR) as 3-bit localparams. The downstream decoder uses the same package.
//  - One sub-module, fifo_mem: a DEPTH x DATA_W register file with one write port and a
//    registered read port, parameterized by DATA_W and ADDR_W. It honours FIFO_MEM_CLR_EN.
//  - fifo_ctrl contains the next-state logic, pointer/count registers and the fifo_mem instance.
// TESTING
//  1. Reset: assert rst for 2 cycles with wr_en=1 -> state=000, data_count=0, dout=0.
//     No write occurs; the first read after fill returns the first post-reset word.
//  2. Fill: write 0xA0..0xA7 on 8 consecutive cycles -> state=010 each cycle, data_count
//     steps 1..8. A 9th write of 0xFF -> state=011, data_count stays 8, and 0xFF is never read.
//  3. Drain: 8 reads -> state=100 and dout=0xA0..0xA7 in order, data_count steps 7..0.
//     A 9th read -> state=101, data_count=0, dout holds 0xA7.
//  4. Wrap: write 5, read 5, write 6, read 6 -> read data is correct across the 7->0 pointer
//     wrap, and data_count returns to 0.
//  5. Simultaneous: with count=3, wr_en=rd_en=1 for 2 cycles -> state=001, data_count=3,
//     dout and pointers unchanged.
//  6. Mid-op reset: with count=5, assert rst together with rd_en -> next cycle state=000,
//     data_count=0. With FIFO_MEM_CLR_EN defined, a write of 0x11 followed by a read returns
//     0x11 and memory readback is 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared state encodings for the FIFO control stage and the downstream flag/ack decoder.
package fifo_pkg;
    localparam logic [2:0] ST_INIT     = 3'b000;
    localparam logic [2:0] ST_NO_OP    = 3'b001;
    localparam logic [2:0] ST_WRITE    = 3'b010;
    localparam logic [2:0] ST_WR_ERROR = 3'b011;
    localparam logic [2:0] ST_READ     = 3'b100;
    localparam logic [2:0] ST_RD_ERROR = 3'b101;
endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register file, one write port, registered read port.
// Define FIFO_MEM_CLR_EN to have rst clear every entry; otherwise contents survive reset.
module fifo_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

`ifdef FIFO_MEM_CLR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end
`else
    // No reset on storage; the controller gates we_i with rst.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst)       rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/fifo_ctrl.sv
// FIFO control/storage stage: request arbitration, head/tail pointers, occupancy and memory.
// Build option FIFO_MEM_CLR_EN (handled in fifo_mem) clears the storage on reset.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  data_count
);
    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              we_d, re_d;

    always_comb begin
        state_d = ST_NO_OP;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we_d    = 1'b0;
        re_d    = 1'b0;
        if (wr_en && !rd_en) begin
            if (count_q != CNT_W'(DEPTH)) begin
                state_d = ST_WRITE;
                we_d    = 1'b1;
                tail_d  = tail_q + ADDR_W'(1);
                count_d = count_q + CNT_W'(1);
            end else begin
                state_d = ST_WR_ERROR;
            end
        end else if (rd_en && !wr_en) begin
            if (count_q != '0) begin
                state_d = ST_READ;
                re_d    = 1'b1;
                head_d  = head_q + ADDR_W'(1);
                count_d = count_q - CNT_W'(1);
            end else begin
                state_d = ST_RD_ERROR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Reset must win over a same-cycle request, so the memory never sees it.
    fifo_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we_d && !rst),
        .waddr_i (tail_q),
        .wdata_i (din),
        .re_i    (re_d && !rst),
        .raddr_i (head_q),
        .rdata_o (dout)
    );

    assign state      = state_q;
    assign data_count = count_q;
endmodule
